// File: rtl/mac_tx_framer.sv
// mac_tx_framer: wraps an AXI-stream payload into an Ethernet frame
// (preamble, SFD, zero pad, CRC-32 FCS), then spaces frames by an IFG.
module mac_tx_framer #(
   parameter int unsigned MIN_LEN = 60,
   parameter int unsigned MAX_LEN = 1514,
   parameter int unsigned IFG_LEN = 12
) (
   input  logic        mac_tx_clk,
   input  logic        rst_n,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic [7:0]  mac_tx_data,
   output logic        mac_tx_valid,
   output logic        mac_tx_sof,
   output logic        mac_tx_eof,
   output logic        frame_done_o,
   output logic        frame_err_o,
   output logic [15:0] frame_cnt_o
);

   typedef enum logic [2:0] {
      IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN
   } state_t;

   localparam logic [11:0] MIN_L = 12'(MIN_LEN);
   localparam logic [11:0] MAX_L = 12'(MAX_LEN);
   localparam logic [15:0] IFG_LAST =
      (IFG_LEN == 0) ? 16'd0 : 16'(IFG_LEN - 1);

   state_t      state;
   state_t      state_nxt;
   logic [10:0] len_cnt;
   logic [11:0] len_inc;
   logic [15:0] step_cnt;
   logic [31:0] crc;
   logic        bad_fcs;
   logic        drain;
   logic        accept;
   logic        underrun;
   logic        oversize;
   logic        last_fcs;
   logic        ifg_end;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;
   logic        crc_en;
   logic [7:0]  crc_in;
   logic [7:0]  tx_data_nxt;
   logic        tx_valid_nxt;
   logic        sof_nxt;
   logic        eof_nxt;
   logic        done_nxt;
   logic        err_nxt;

   function automatic logic [31:0] crc_step(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign s_axis_tready = (state == DATA) || (state == DRAIN);
   assign accept   = s_axis_tvalid && s_axis_tready;
   assign len_inc  = {1'b0, len_cnt} + 12'd1;
   assign underrun = (state == DATA) && !s_axis_tvalid;
   assign oversize = (state == DATA) && s_axis_tvalid
                     && !s_axis_tlast && (len_inc == MAX_L);
   assign last_fcs = (state == FCS) && (step_cnt[1:0] == 2'd3);
   assign ifg_end  = (step_cnt == IFG_LAST);

   // an aborted frame sends the raw register, i.e. the inverted FCS
   assign fcs_word = bad_fcs ? crc : ~crc;
   assign fcs_byte = 8'(fcs_word >> {step_cnt[1:0], 3'b000});

   always_ff @(posedge mac_tx_clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (s_axis_tvalid)
               state_nxt = PRE;
         PRE:
            if (step_cnt[2:0] == 3'd5)
               state_nxt = SFD;
         SFD:
            state_nxt = DATA;
         DATA: begin
            if (underrun || oversize)
               state_nxt = FCS;
            else if (s_axis_tlast)
               state_nxt = (len_inc < MIN_L) ? PAD : FCS;
         end
         PAD:
            if (len_inc >= MIN_L)
               state_nxt = FCS;
         FCS:
            if (last_fcs)
               state_nxt = IFG;
         IFG:
            if (ifg_end)
               state_nxt = drain ? DRAIN : IDLE;
         DRAIN:
            if (accept && s_axis_tlast)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // values loaded into the wire registers on the coming edge
   always_comb begin
      tx_valid_nxt = 1'b0;
      tx_data_nxt  = 8'h00;
      sof_nxt      = 1'b0;
      eof_nxt      = 1'b0;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      crc_en       = 1'b0;
      crc_in       = 8'h00;
      unique case (state)
         IDLE:
            if (s_axis_tvalid) begin
               tx_valid_nxt = 1'b1;
               tx_data_nxt  = 8'h55;
               sof_nxt      = 1'b1;
            end
         PRE: begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = 8'h55;
         end
         SFD: begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = 8'hD5;
         end
         DATA: begin
            tx_valid_nxt = 1'b1;
            err_nxt      = underrun || oversize;
            if (s_axis_tvalid) begin
               tx_data_nxt = s_axis_tdata;
               crc_en      = 1'b1;
               crc_in      = s_axis_tdata;
            end else begin
               // underrun: first bad FCS byte fills the slot
               tx_data_nxt = crc[7:0];
            end
         end
         PAD: begin
            tx_valid_nxt = 1'b1;
            crc_en       = 1'b1;
         end
         FCS: begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = fcs_byte;
            eof_nxt      = last_fcs;
            done_nxt     = last_fcs;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge mac_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt    <= '0;
         len_cnt     <= '0;
         crc         <= '1;
         bad_fcs     <= 1'b0;
         drain       <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         if (state_nxt != state)
            step_cnt <= underrun ? 16'd1 : 16'd0;
         else
            step_cnt <= step_cnt + 16'd1;

         if (state == IDLE) begin
            len_cnt <= '0;
            crc     <= '1;
            bad_fcs <= 1'b0;
         end else if (crc_en) begin
            crc <= crc_step(crc, crc_in);
            if (len_cnt != MAX_L[10:0])
               len_cnt <= len_cnt + 11'd1;
         end

         if (underrun || oversize)
            bad_fcs <= 1'b1;

         if (last_fcs) begin
            drain       <= bad_fcs;
            frame_cnt_o <= frame_cnt_o + 16'd1;
         end else if (state == DRAIN && accept && s_axis_tlast) begin
            drain <= 1'b0;
         end
      end
   end

   always_ff @(posedge mac_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_tx_data  <= 8'h00;
         mac_tx_valid <= 1'b0;
         mac_tx_sof   <= 1'b0;
         mac_tx_eof   <= 1'b0;
         frame_done_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         mac_tx_data  <= tx_data_nxt;
         mac_tx_valid <= tx_valid_nxt;
         mac_tx_sof   <= sof_nxt;
         mac_tx_eof   <= eof_nxt;
         frame_done_o <= done_nxt;
         frame_err_o  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: directed framing, pad, FCS, IFG, abort/drain
// and asynchronous reset scenarios with hand-derived expectations.
module tb_mac_tx_framer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tlast;

   logic        tvalid_a, tvalid_b;
   logic        tready_a, tready_b;
   logic [7:0]  data_a, data_b;
   logic        valid_a, valid_b;
   logic        sof_a, sof_b, eof_a, eof_b;
   logic        done_a, done_b, err_a, err_b;
   logic [15:0] cnt_a, cnt_b;

   logic        m_tready, m_valid, m_sof, m_eof, m_done, m_err;
   logic [7:0]  m_data;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   assign tvalid_a = tvalid && !sel;
   assign tvalid_b = tvalid && sel;
   assign m_tready = sel ? tready_b : tready_a;
   assign m_valid  = sel ? valid_b : valid_a;
   assign m_data   = sel ? data_b : data_a;
   assign m_sof    = sel ? sof_b : sof_a;
   assign m_eof    = sel ? eof_b : eof_a;
   assign m_done   = sel ? done_b : done_a;
   assign m_err    = sel ? err_b : err_a;
   assign m_cnt    = sel ? cnt_b : cnt_a;

   mac_tx_framer dut (
      .mac_tx_clk    (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid_a),
      .s_axis_tlast  (tlast),
      .s_axis_tready (tready_a),
      .mac_tx_data   (data_a),
      .mac_tx_valid  (valid_a),
      .mac_tx_sof    (sof_a),
      .mac_tx_eof    (eof_a),
      .frame_done_o  (done_a),
      .frame_err_o   (err_a),
      .frame_cnt_o   (cnt_a)
   );

   mac_tx_framer #(.MIN_LEN(0)) dut_np (
      .mac_tx_clk    (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid_b),
      .s_axis_tlast  (tlast),
      .s_axis_tready (tready_b),
      .mac_tx_data   (data_b),
      .mac_tx_valid  (valid_b),
      .mac_tx_sof    (sof_b),
      .mac_tx_eof    (eof_b),
      .frame_done_o  (done_b),
      .frame_err_o   (err_b),
      .frame_cnt_o   (cnt_b)
   );

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int eof_cyc = -100;
   int sof_cyc = 0;
   int gap_last = 0;
   int eof_total = 0;
   int err_total = 0;
   int done_total = 0;
   int valid_total = 0;
   int valid_at_eof = 0;
   int gap_in_frame = 0;
   int idle_dirty = 0;
   int done_skew = 0;
   bit in_frame = 1'b0;
   int drv_start = 0;

   logic [7:0] byte_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] pay[$];

   int e0, d0, r0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         in_frame = 1'b0;
      end else begin
         if (m_valid) begin
            valid_total++;
            if (m_sof) begin
               byte_q.delete();
               gap_last = cyc - eof_cyc - 1;
               sof_cyc  = cyc;
               in_frame = 1'b1;
            end
            byte_q.push_back(m_data);
            if (m_eof) begin
               eof_cyc      = cyc;
               eof_total++;
               valid_at_eof = valid_total;
               in_frame     = 1'b0;
            end
         end else begin
            if (in_frame)
               gap_in_frame++;
            if (m_data != 8'h00 || m_sof || m_eof)
               idle_dirty++;
         end
         if (m_err)
            err_total++;
         if (m_done)
            done_total++;
         if (m_done != m_eof)
            done_skew++;
      end
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k])
            r = (r >> 1) ^ 32'hEDB8_8320;
         else
            r = r >> 1;
      end
      return r;
   endfunction

   task automatic build_exp(input int min_len, input bit bad, input int n);
      logic [31:0] c;
      int tot;
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pay[i]);
         c = crc_upd(c, pay[i]);
      end
      tot = n;
      while (!bad && tot < min_len) begin
         exp_q.push_back(8'h00);
         c = crc_upd(c, 8'h00);
         tot++;
      end
      if (!bad)
         c = ~c;
      for (int k = 0; k < 4; k++)
         exp_q.push_back(c[8*k +: 8]);
   endtask

   task automatic compare_frame(input string tag);
      int n;
      check({tag, "_len"}, byte_q.size(), exp_q.size());
      n = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_b%0d", tag, i), byte_q[i], exp_q[i]);
   endtask

   task automatic idle_in();
      tvalid = 1'b0;
      tlast  = 1'b0;
      tdata  = 8'h00;
   endtask

   task automatic send(input int n, input int gap_at, input int gap_len);
      int i;
      int k;
      logic acc;
      i = 0;
      k = 0;
      drv_start = cyc;
      while (i < n && k < 5000) begin
         if (i == gap_at && gap_len > 0) begin
            idle_in();
            repeat (gap_len) begin
               @(negedge clk);
               #1;
            end
            gap_len = 0;
         end
         tvalid = 1'b1;
         tdata  = pay[i];
         tlast  = (i == n - 1);
         acc    = m_tready;
         @(negedge clk);
         #1;
         if (acc)
            i++;
         k++;
      end
      check("send_done", i, n);
   endtask

   task automatic wait_eof(input int target);
      int k;
      k = 0;
      while (eof_total < target && k < 4000) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("eof_wait", (eof_total >= target), 1);
   endtask

   task automatic pause(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      sel    = 1'b0;
      rst_n  = 1'b0;
      tvalid = 1'b1;
      tlast  = 1'b0;
      tdata  = 8'h5A;
      pause(3);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_sof", m_sof, 0);
      check("rst_eof", m_eof, 0);
      check("rst_done", m_done, 0);
      check("rst_err", m_err, 0);
      check("rst_cnt", m_cnt, 0);
      check("rst_tready", m_tready, 0);
      check("rst_cnt_np", cnt_b, 0);
      idle_in();
      rst_n = 1'b1;
      pause(2);

      // "123456789" without padding
      sel = 1'b1;
      pay.delete();
      for (int i = 0; i < 9; i++)
         pay.push_back(8'h31 + 8'(i));
      e0 = eof_total; d0 = done_total; r0 = err_total;
      send(9, -1, 0);
      idle_in();
      wait_eof(e0 + 1);
      build_exp(0, 1'b0, 9);
      compare_frame("nopad");
      check("nopad_fcs0", byte_q[17], 8'h26);
      check("nopad_fcs1", byte_q[18], 8'h39);
      check("nopad_fcs2", byte_q[19], 8'hF4);
      check("nopad_fcs3", byte_q[20], 8'hCB);
      check("nopad_sof_lat", sof_cyc, drv_start + 1);
      check("nopad_cnt", cnt_b, 1);
      check("nopad_done", done_total - d0, 1);
      check("nopad_err", err_total - r0, 0);
      pause(2);

      // single byte padded to 60
      sel = 1'b0;
      pay.delete();
      pay.push_back(8'hAB);
      e0 = eof_total; r0 = err_total;
      send(1, -1, 0);
      idle_in();
      wait_eof(e0 + 1);
      build_exp(60, 1'b0, 1);
      compare_frame("pad1");
      check("pad1_sof_lat", sof_cyc, drv_start + 1);
      check("pad1_cnt", cnt_a, 1);
      check("pad1_err", err_total - r0, 0);

      // two 64-byte frames back to back
      pay.delete();
      for (int i = 0; i < 64; i++)
         pay.push_back(8'(i * 3 + 1));
      e0 = eof_total;
      send(64, -1, 0);
      send(64, -1, 0);
      idle_in();
      wait_eof(e0 + 2);
      build_exp(60, 1'b0, 64);
      compare_frame("b2b");
      check("b2b_ifg", gap_last, 12);
      check("b2b_eofs", eof_total - e0, 2);
      check("b2b_cnt", cnt_a, 3);

      // underrun after 20 bytes, tlast at 30
      pay.delete();
      for (int i = 0; i < 30; i++)
         pay.push_back(8'(i + 1));
      e0 = eof_total; d0 = done_total; r0 = err_total;
      send(30, 20, 3);
      idle_in();
      wait_eof(e0 + 1);
      pause(3);
      build_exp(60, 1'b1, 20);
      compare_frame("underrun");
      check("underrun_err", err_total - r0, 1);
      check("underrun_done", done_total - d0, 1);
      check("underrun_cnt", cnt_a, 4);
      check("underrun_quiet", valid_total, valid_at_eof);
      check("underrun_idle", m_tready, 0);
      pay.delete();
      pay.push_back(8'hAB);
      e0 = eof_total;
      send(1, -1, 0);
      idle_in();
      wait_eof(e0 + 1);
      build_exp(60, 1'b0, 1);
      compare_frame("post_drain");
      check("post_drain_cnt", cnt_a, 5);

      // tlast exactly on the MAX_LEN byte is a good frame
      pay.delete();
      for (int i = 0; i < 1600; i++)
         pay.push_back(8'(i) ^ 8'h5C);
      e0 = eof_total; r0 = err_total;
      send(1514, -1, 0);
      idle_in();
      wait_eof(e0 + 1);
      build_exp(60, 1'b0, 1514);
      compare_frame("max_tlast");
      check("max_tlast_err", err_total - r0, 0);
      check("max_tlast_cnt", cnt_a, 6);

      // 1600-byte oversize frame
      e0 = eof_total; r0 = err_total;
      send(1600, -1, 0);
      idle_in();
      wait_eof(e0 + 1);
      pause(3);
      build_exp(60, 1'b1, 1514);
      compare_frame("oversize");
      check("oversize_err", err_total - r0, 1);
      check("oversize_quiet", valid_total, valid_at_eof);
      check("oversize_cnt", cnt_a, 7);
      check("oversize_idle", m_tready, 0);

      // asynchronous reset in the middle of DATA
      d0 = done_total; r0 = err_total;
      tvalid = 1'b1;
      tdata  = 8'h77;
      tlast  = 1'b0;
      pause(12);
      check("arst_pre_valid", m_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", m_valid, 0);
      check("arst_data", m_data, 0);
      check("arst_sof", m_sof, 0);
      check("arst_eof", m_eof, 0);
      check("arst_cnt", m_cnt, 0);
      check("arst_tready", m_tready, 0);
      idle_in();
      pause(2);
      rst_n = 1'b1;
      pause(1);
      check("arst_no_err", err_total - r0, 0);
      check("arst_no_done", done_total - d0, 0);
      pay.delete();
      pay.push_back(8'hAB);
      e0 = eof_total;
      send(1, -1, 0);
      idle_in();
      wait_eof(e0 + 1);
      build_exp(60, 1'b0, 1);
      compare_frame("after_rst");
      check("after_rst_sof_lat", sof_cyc, drv_start + 1);
      check("after_rst_cnt", cnt_a, 1);

      pause(2);
      check("valid_gaps", gap_in_frame, 0);
      check("idle_clean", idle_dirty, 0);
      check("done_eof_align", done_skew, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_tx_framer.md
MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

Interface
REQ-001 The module SHALL have parameter MIN_LEN, default 60, giving the minimum data+pad byte count before FCS; 0 disables padding.
REQ-002 The module SHALL have parameter MAX_LEN, default 1514, giving the maximum data byte count per frame.
REQ-003 The module SHALL have parameter IFG_LEN, default 12, giving the idle cycles after each frame's last byte.
REQ-004 The module SHALL have port mac_tx_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port s_axis_tdata, input, 8 bits: payload byte.
REQ-007 The module SHALL have port s_axis_tvalid, input, 1 bit: payload byte valid.
REQ-008 The module SHALL have port s_axis_tlast, input, 1 bit: last payload byte.
REQ-009 The module SHALL have port s_axis_tready, output, 1 bit: framer accepts a byte.
REQ-010 The module SHALL have port mac_tx_data, output, 8 bits: wire byte to mac_rgmii.
REQ-011 The module SHALL have port mac_tx_valid, output, 1 bit: wire byte valid.
REQ-012 The module SHALL have port mac_tx_sof, output, 1 bit: first preamble byte.
REQ-013 The module SHALL have port mac_tx_eof, output, 1 bit: last FCS byte.
REQ-014 The module SHALL have port frame_done_o, output, 1 bit: one-cycle pulse with each eof.
REQ-015 The module SHALL have port frame_err_o, output, 1 bit: one-cycle pulse on abort.
REQ-016 The module SHALL have port frame_cnt_o, output, 16 bits: count of completed frames, good or aborted.

Function
REQ-017 The state machine SHALL have the states IDLE, PRE, SFD, DATA, PAD, FCS, IFG and DRAIN.
REQ-018 In IDLE, when s_axis_tvalid=1 the module SHALL go to PRE, and the first preamble byte SHALL appear on the next cycle.
REQ-019 PRE SHALL output 7 bytes of 0x55, with mac_tx_sof=1 on the first only; SFD SHALL then output 1 byte of 0xD5.
REQ-020 s_axis_tready SHALL be 1 only in DATA and DRAIN.
REQ-021 In DATA, each tvalid&tready byte SHALL be output unchanged one cycle later.
REQ-022 Within a frame, mac_tx_valid SHALL be continuous from sof through eof, with no gaps.
REQ-023 In DATA, on tlast accepted: if the data count is below MIN_LEN the module SHALL go to PAD, otherwise to FCS.
REQ-024 PAD SHALL output 0x00 until the data+pad count equals MIN_LEN, then go to FCS.
REQ-025 The CRC SHALL be IEEE 802.3 CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
REQ-026 The CRC SHALL cover data and pad bytes only, excluding preamble and SFD.
REQ-027 FCS SHALL output 4 bytes, least-significant byte first, with mac_tx_eof=1 on the 4th byte; frame_done_o and the frame_cnt_o increment SHALL occur in that same cycle.
REQ-028 Underrun: if s_axis_tvalid=0 in DATA, the module SHALL abort the frame.
REQ-029 Oversize: if MAX_LEN bytes are accepted without tlast, the module SHALL abort the frame.
REQ-030 On abort, the module SHALL pulse frame_err_o, skip PAD, and output the 4 FCS bytes bit-inverted (a guaranteed bad FCS).
REQ-031 After an aborted frame's FCS, the module SHALL set a drain flag.
REQ-032 IFG SHALL hold mac_tx_valid=0 for exactly IFG_LEN cycles, then go to DRAIN if the drain flag is set, otherwise to IDLE.
REQ-033 DRAIN SHALL discard input bytes with tready=1 and no output until tlast is accepted, then clear the drain flag and go to IDLE.
REQ-034 If the abort byte itself carried tlast, the module SHALL skip DRAIN.
REQ-035 When mac_tx_valid=0, mac_tx_data SHALL be 0x00 and sof and eof SHALL be 0.
REQ-036 The data counter SHALL be 11 bits wide and saturate at MAX_LEN.
REQ-037 frame_cnt_o SHALL wrap from 0xFFFF to 0x0000.
REQ-038 tlast on the byte that reaches MAX_LEN SHALL be treated as a normal end of frame, not an abort.

Reset
REQ-039 While rst_n=0, state SHALL be IDLE and all outputs 0, with frame_cnt_o=0 and the drain flag cleared.
REQ-040 Assertion of rst_n mid-frame SHALL truncate the frame immediately with no eof; no frame_done_o or frame_err_o pulse SHALL be generated.
REQ-041 After rst_n deasserts, the first frame SHALL start without any IFG wait.

Verification
REQ-042 MIN_LEN=0, payload "123456789" (0x31..0x39) -> output 55x7, D5, 31..39, then 26 39 F4 CB; eof on CB; frame_cnt_o=1.
REQ-043 Default parameters, 1-byte payload 0xAB -> 72 valid bytes (8 preamble/SFD + AB + 59x00 + 4 FCS); FCS matches the reference CRC model.
REQ-044 Two back-to-back 64-byte payloads with tvalid held high -> exactly 12 idle cycles between the first eof and the second sof.
REQ-045 tvalid dropped after 20 data bytes, tlast at byte 30 -> 4 inverted-FCS bytes after byte 20, one frame_err_o pulse, bytes 21-30 drained, and no output until the following frame.
REQ-046 1600-byte payload -> 1514 data bytes then bad FCS, frame_err_o=1, remaining 86 bytes drained.
REQ-047 rst_n pulsed low during DATA -> outputs 0 within the same cycle (asynchronous); a new frame starts cleanly with sof afterward.
